// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package shift_ctrl_pkg;

  // Sequencer states; encoding is fixed so debug taps read the same everywhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Request modes latched with start.
  localparam logic MODE_LOAD_SHIFT = 1'b0;
  localparam logic MODE_SHIFT_ONLY = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Requester/shift-register side bundle of the shift sequencer.
// Latency: none (wires only).
// Backpressure: none; start is a pulse, busy tells the requester to wait.
interface shift_seq_ctrl_if #(
  parameter int CNT_W = 7
);

  // Requester -> sequencer
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] shift_len;
  logic             abort;

  // Sequencer -> shift register / requester
  logic             par_load;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  // Requester view
  modport master (
    output start, mode, shift_len, abort,
    input  par_load, shift_en, busy, done, bit_cnt
  );

  // Sequencer view
  modport slave (
    input  start, mode, shift_len, abort,
    output par_load, shift_en, busy, done, bit_cnt
  );

endinterface

// File: rtl/shift_seq_ctrl_bit_counter.sv
// Shift counter with sync clear, enable and a terminal flag (count+1 == limit).
// Latency: count updates one edge after en; term is combinational from count.
// Backpressure: none; en simply holds the count when low.
module bit_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  // Count register: reset and clear win over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal flag: the next increment reaches the limit.
  always_comb begin
    term = ((count + CNT_W'(1)) == limit);
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences Par_load / shift_en for one shift register: optional load, then N shifts.
// Latency: start at edge 0 -> LOAD cycle 1, SHIFT cycles 2..N+1, DONE N+2 (mode1 drops LOAD).
// Backpressure: start is only taken in IDLE; busy is high while an operation runs.
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = 7   // 2**CNT_W must exceed WIDTH so bit_cnt can never wrap
) (
  input  logic           clk,
  input  logic           rst,
  shift_seq_ctrl_if.slave ctrl
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] len_q;
  logic             mode_q;
  logic [CNT_W-1:0] len_clamped;
  logic             accept;
  logic             cnt_en;
  logic             cnt_term;
  logic [CNT_W-1:0] cnt;

  // A request is taken only in IDLE, and a coincident abort drops it.
  assign accept      = (state_q == IDLE) && ctrl.start && !ctrl.abort;
  assign len_clamped = (ctrl.shift_len > LEN_MAX) ? LEN_MAX : ctrl.shift_len;
  // An abort freezes the count at the shifts already completed.
  assign cnt_en      = (state_q == SHIFT) && !ctrl.abort;

  bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (cnt_en),
    .limit (len_q),
    .count (cnt),
    .term  (cnt_term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch length and mode with the accepted start so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      mode_q <= MODE_LOAD_SHIFT;
    end else if (accept) begin
      len_q  <= len_clamped;
      mode_q <= ctrl.mode;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl.mode == MODE_LOAD_SHIFT) begin
            state_d = LOAD;
          end else if (len_clamped != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (ctrl.abort) begin
          state_d = IDLE;
        end else if (len_q != '0) begin
          state_d = SHIFT;
        end else begin
          state_d = DONE;
        end
      end
      SHIFT: begin
        if (ctrl.abort) begin
          state_d = IDLE;
        end else if (cnt_term) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode; LOAD and SHIFT are exclusive so par_load/shift_en never overlap.
  always_comb begin
    ctrl.par_load = 1'b0;
    ctrl.shift_en = 1'b0;
    ctrl.busy     = 1'b0;
    ctrl.done     = 1'b0;
    case (state_q)
      LOAD: begin
        // LOAD is only reachable for load-then-shift requests; qualify with the latched mode anyway.
        ctrl.par_load = (mode_q == MODE_LOAD_SHIFT);
        ctrl.busy     = 1'b1;
      end
      SHIFT: begin
        ctrl.shift_en = 1'b1;
        ctrl.busy     = 1'b1;
      end
      DONE: begin
        ctrl.done = 1'b1;
      end
      default: begin
        ctrl.busy = 1'b0;
      end
    endcase
  end

  assign ctrl.bit_cnt = cnt;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at WIDTH=24 and WIDTH=80.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: requester waits for done/IDLE before issuing the next start.
module tb_shift_seq_ctrl;
  import shift_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.CNT_W(7)) ifa ();
  shift_seq_ctrl_if #(.CNT_W(7)) ifb ();

  shift_seq_ctrl #(.WIDTH(24), .CNT_W(7)) u_dut24 (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifa.slave)
  );

  shift_seq_ctrl #(.WIDTH(80), .CNT_W(7)) u_dut80 (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifb.slave)
  );

  // Simple 24-bit shift register driven by the sequencer, MSB out first.
  logic [23:0] par_data;
  logic [23:0] sreg = '0;
  logic [23:0] cap  = '0;

  always @(posedge clk) begin
    if (ifa.par_load)      sreg <= par_data;
    else if (ifa.shift_en) sreg <= {sreg[22:0], 1'b0};
  end

  // Capture the serial output in every shift cycle.
  always @(negedge clk) begin
    if (ifa.shift_en) cap <= {cap[22:0], sreg[23]};
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic m, input logic [6:0] len);
    ifa.start     = 1'b1;
    ifa.mode      = m;
    ifa.shift_len = len;
    step();
    ifa.start     = 1'b0;
  endtask

  // Observe from cycle 1 until done (or budget runs out); ends in the DONE cycle.
  task automatic run_op(input int budget, output int pl, output int se, output int both,
                        output int done_at, output int cnt_at_done);
    pl = 0; se = 0; both = 0; done_at = -1; cnt_at_done = -1;
    for (int i = 1; i <= budget; i++) begin
      if (ifa.par_load) pl++;
      if (ifa.shift_en) se++;
      if (ifa.par_load && ifa.shift_en) both++;
      if (ifa.done) begin
        done_at     = i;
        cnt_at_done = int'(ifa.bit_cnt);
        break;
      end
      step();
    end
  endtask

  int pl, se, both, dat, cad, dn, d1, d2;

  initial begin
    ifa.start = 1'b0; ifa.mode = 1'b0; ifa.shift_len = '0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.mode = 1'b0; ifb.shift_len = '0; ifb.abort = 1'b0;
    par_data  = 24'hA5A5A5;
    rst = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_par_load", int'(ifa.par_load), 0);
    chk("rst_shift_en", int'(ifa.shift_en), 0);
    chk("rst_busy",     int'(ifa.busy), 0);
    chk("rst_done",     int'(ifa.done), 0);
    chk("rst_bit_cnt",  int'(ifa.bit_cnt), 0);
    chk("rst_state",    int'(u_dut24.state_q), int'(IDLE));
    rst = 1'b0;
    step();

    // mode0, len=24, load A5A5A5 and shift it out
    kick(1'b0, 7'd24);
    run_op(40, pl, se, both, dat, cad);
    chk("m0l24_par_load_cycles", pl, 1);
    chk("m0l24_shift_cycles",    se, 24);
    chk("m0l24_overlap",         both, 0);
    chk("m0l24_done_cycle",      dat, 26);
    chk("m0l24_cnt_at_done",     cad, 24);
    step();
    chk("m0l24_idle_after",      int'(u_dut24.state_q), int'(IDLE));
    chk("m0l24_done_one_cycle",  int'(ifa.done), 0);
    chk("m0l24_cnt_hold",        int'(ifa.bit_cnt), 24);
    chk("m0l24_ser_stream",      int'(cap), 'hA5A5A5);

    // mode1, len=0
    kick(1'b1, 7'd0);
    run_op(10, pl, se, both, dat, cad);
    chk("m1l0_par_load", pl, 0);
    chk("m1l0_shift",    se, 0);
    chk("m1l0_done",     dat, 1);
    step();

    // mode0, len=0
    kick(1'b0, 7'd0);
    run_op(10, pl, se, both, dat, cad);
    chk("m0l0_par_load", pl, 1);
    chk("m0l0_shift",    se, 0);
    chk("m0l0_done",     dat, 2);
    step();

    // len=30 clamps to 24
    kick(1'b1, 7'd30);
    run_op(40, pl, se, both, dat, cad);
    chk("clamp_shift",  se, 24);
    chk("clamp_cnt",    cad, 24);
    chk("clamp_done",   dat, 25);
    step();

    // Second start during SHIFT ignored; abort at bit_cnt=10
    kick(1'b1, 7'd20);
    dn = 0;
    for (int i = 1; i < 11; i++) begin
      if (ifa.done) dn++;
      if (i == 4) begin
        ifa.start = 1'b1; ifa.mode = 1'b0; ifa.shift_len = 7'd5;
      end else begin
        ifa.start = 1'b0;
      end
      step();
    end
    chk("restart_ignored_cnt",   int'(ifa.bit_cnt), 10);
    chk("restart_ignored_state", int'(u_dut24.state_q), int'(SHIFT));
    ifa.abort = 1'b1;
    step();
    ifa.abort = 1'b0;
    chk("abort_state", int'(u_dut24.state_q), int'(IDLE));
    chk("abort_busy",  int'(ifa.busy), 0);
    chk("abort_cnt",   int'(ifa.bit_cnt), 10);
    for (int i = 0; i < 4; i++) begin
      if (ifa.done) dn++;
      step();
    end
    chk("abort_no_done", dn, 0);

    // abort together with start in IDLE drops the start
    ifa.start = 1'b1; ifa.abort = 1'b1; ifa.mode = 1'b1; ifa.shift_len = 7'd3;
    step();
    ifa.start = 1'b0; ifa.abort = 1'b0;
    chk("abort_start_state", int'(u_dut24.state_q), int'(IDLE));
    chk("abort_start_cnt",   int'(ifa.bit_cnt), 10);
    step();

    // Reset mid-SHIFT at bit_cnt=5
    kick(1'b1, 7'd20);
    for (int i = 0; i < 5; i++) step();
    chk("midrst_pre_cnt", int'(ifa.bit_cnt), 5);
    rst = 1'b1;
    step();
    chk("midrst_par_load", int'(ifa.par_load), 0);
    chk("midrst_shift_en", int'(ifa.shift_en), 0);
    chk("midrst_busy",     int'(ifa.busy), 0);
    chk("midrst_done",     int'(ifa.done), 0);
    chk("midrst_cnt",      int'(ifa.bit_cnt), 0);
    chk("midrst_state",    int'(u_dut24.state_q), int'(IDLE));
    rst = 1'b0;
    step();

    // WIDTH=80: back-to-back mode1 len=80 with start held high
    ifb.start = 1'b1; ifb.mode = 1'b1; ifb.shift_len = 7'd80;
    step();
    dn = 0; d1 = -1; d2 = -1; se = 0;
    for (int i = 1; i <= 200; i++) begin
      if (ifb.shift_en) se++;
      if (ifb.done) begin
        dn++;
        if (dn == 1) d1 = i;
        else if (dn == 2) d2 = i;
      end
      if (i == 82) chk("w80_gap_busy", int'(ifb.busy), 0);
      if (i == 83) begin
        chk("w80_second_shift", int'(ifb.shift_en), 1);
        chk("w80_second_cnt",   int'(ifb.bit_cnt), 0);
        ifb.start = 1'b0;
      end
      step();
    end
    chk("w80_done_count",  dn, 2);
    chk("w80_first_done",  d1, 81);
    chk("w80_second_done", d2, 163);
    chk("w80_shift_total", se, 160);
    chk("w80_final_cnt",   int'(ifb.bit_cnt), 80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
